// File: rtl/cgol_gen_sequencer.sv
// Game of Life generation sequencer: scans rows for display, runs the
// snapshot/compute passes of a generation, and services host row loads.
module cgol_gen_sequencer #(
  parameter int HOLDW = 6,
  parameter int GENW  = 8
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [HOLDW-1:0] hold_frames,
  input  logic             load_req,
  input  logic [2:0]       load_addr,
  output logic             load_ack,
  output logic [2:0]       addr,
  output logic             prev_we,
  output logic             cur_we,
  output logic             cur_wsel,
  output logic             disp_en,
  output logic             frame_done,
  output logic             busy,
  output logic [GENW-1:0]  gen_count
);

  typedef enum logic [1:0] {
    DISP = 2'd0,
    SNAP = 2'd1,
    COMP = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [HOLDW-1:0] frame_cnt_q, frame_cnt_d;
  logic             step_pend_q, step_pend_d;
  logic [GENW-1:0]  gen_count_q, gen_count_d;
  logic [HOLDW-1:0] hold_eff;
  logic             last_row;

  // A hold of zero frames behaves exactly like a hold of one.
  assign hold_eff = (hold_frames == '0) ? HOLDW'(1) : hold_frames;
  assign last_row = (addr_q == 3'd7);

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;
    gen_count_d = gen_count_q;
    step_pend_d = step_pend_q | (step & ~run);

    unique case (state_q)
      DISP: begin
        addr_d = addr_q + 3'd1;
        if (last_row) begin
          if (load_req) begin
            state_d     = LOAD;
            frame_cnt_d = '0;
          end else if ((run && (frame_cnt_q >= hold_eff - HOLDW'(1))) ||
                       (!run && step_pend_q)) begin
            state_d     = SNAP;
            frame_cnt_d = '0;
            // A fresh step arriving on the entry cycle is kept, not lost.
            step_pend_d = step & ~run;
          end else if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + HOLDW'(1);
          end
        end
      end
      SNAP: begin
        addr_d = addr_q + 3'd1;
        if (last_row) state_d = COMP;
      end
      COMP: begin
        addr_d = addr_q + 3'd1;
        if (last_row) begin
          state_d     = DISP;
          gen_count_d = gen_count_q + GENW'(1);
        end
      end
      LOAD: begin
        if (!load_req) begin
          state_d     = DISP;
          addr_d      = 3'd0;
          gen_count_d = '0;
        end
      end
      default: state_d = DISP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q     <= DISP;
      addr_q      <= 3'd0;
      frame_cnt_q <= '0;
      step_pend_q <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      gen_count_q <= gen_count_d;
    end
  end

  // Moore decode, except the host-driven address and write strobe in LOAD.
  always_comb begin
    addr       = addr_q;
    prev_we    = 1'b0;
    cur_we     = 1'b0;
    cur_wsel   = 1'b0;
    disp_en    = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    load_ack   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        DISP: begin
          disp_en    = 1'b1;
          frame_done = last_row;
        end
        SNAP: begin
          prev_we = 1'b1;
          busy    = 1'b1;
        end
        COMP: begin
          cur_we = 1'b1;
          busy   = 1'b1;
        end
        LOAD: begin
          addr     = load_addr;
          cur_we   = load_req;
          load_ack = load_req;
          cur_wsel = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gen_count = gen_count_q;

endmodule
